// File: rtl/divisor_if.sv
// Operand/result bundle for the sequential signed divider.
interface divisor_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Cociente;
  logic [WIDTH-1:0] Residuo;

  modport master (output A, output B, input Cociente, input Residuo);
  modport slave  (input A, input B, output Cociente, output Residuo);
endinterface

// File: rtl/divisor.sv
// Free-running signed restoring divider: LOAD (1) -> CALC (WIDTH) -> DONE (1).
// state | meaning
// LOAD  | sample A/B, record signs, form magnitudes, clear remainder/counter
// CALC  | one restoring quotient bit per cycle, MSB first
// DONE  | apply signs and divide-by-zero override, register outputs
module divisor #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  divisor_if.slave  dif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH:0]   abs_b_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic [WIDTH-1:0] coc_q;
  logic [WIDTH-1:0] res_q;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH:0]   abs_b;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] coc_d;
  logic [WIDTH-1:0] res_d;

  // -MIN is representable as an unsigned WIDTH-bit magnitude.
  assign abs_a = dif.A[WIDTH-1] ? (~dif.A + 1'b1) : dif.A;
  assign abs_b = {1'b0, (dif.B[WIDTH-1] ? (~dif.B + 1'b1) : dif.B)};

  // Borrow out of the top bit marks a failed trial subtraction.
  assign trial = {rem_q, dvd_q[WIDTH-1]} - {1'b0, abs_b_q};

  always_comb begin
    coc_d = sign_q_q ? (~dvd_q + 1'b1) : dvd_q;
    res_d = sign_r_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
    if (abs_b_q == '0) begin
      coc_d = '1;
      res_d = a_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      a_q      <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      abs_b_q  <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      coc_q    <= '0;
      res_q    <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          a_q      <= dif.A;
          dvd_q    <= abs_a;
          abs_b_q  <= abs_b;
          sign_q_q <= dif.A[WIDTH-1] ^ dif.B[WIDTH-1];
          sign_r_q <= dif.A[WIDTH-1];
          rem_q    <= '0;
          cnt_q    <= '0;
          state_q  <= CALC;
        end
        CALC: begin
          if (!trial[WIDTH+1]) begin
            rem_q <= trial[WIDTH:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= DONE;
        end
        DONE: begin
          coc_q   <= coc_d;
          res_q   <= res_d;
          state_q <= LOAD;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign dif.Cociente = coc_q;
  assign dif.Residuo  = res_q;
endmodule

// File: tb/tb_divisor.sv
// Randomized self-checking bench for divisor against a plain-arithmetic reference.
module tb_divisor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divisor_if #(.WIDTH(W)) dif ();

  divisor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q = 8'h00;
  logic [7:0] exp_r = 8'h00;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Signed integer division: truncation toward zero, remainder follows dividend.
  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      q = 8'hFF;
      r = a;
    end else begin
      qi = ai / bi;
      ri = ai - qi * bi;
      q  = qi[7:0];
      r  = ri[7:0];
    end
  endfunction

  // Entered just before a LOAD edge; leaves 1 time unit after the DONE edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
    dif.A = a;
    dif.B = b;
    repeat (9) @(posedge clk);
    #1;
    check({tag, " hold_q"}, dif.Cociente, exp_q);
    check({tag, " hold_r"}, dif.Residuo, exp_r);
    ref_div(a, b, exp_q, exp_r);
    @(posedge clk);
    #1;
    check({tag, " q"}, dif.Cociente, exp_q);
    check({tag, " r"}, dif.Residuo, exp_r);
  endtask

  task automatic run_change(input logic [7:0] a0, input logic [7:0] b0,
                            input logic [7:0] a1, input logic [7:0] b1);
    dif.A = a0;
    dif.B = b0;
    repeat (4) @(posedge clk);
    #1;
    dif.A = a1;
    dif.B = b1;
    repeat (5) @(posedge clk);
    #1;
    check("chg hold_q", dif.Cociente, exp_q);
    check("chg hold_r", dif.Residuo, exp_r);
    ref_div(a0, b0, exp_q, exp_r);
    @(posedge clk);
    #1;
    check("chg old_q", dif.Cociente, exp_q);
    check("chg old_r", dif.Residuo, exp_r);
    run_op(a1, b1, "chg new");
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] corners [6];
    corners = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'h01, 8'h02};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return 8'($urandom());
  endfunction

  initial begin
    rst   = 1'b0;
    dif.A = 8'd25;
    dif.B = 8'd1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("rst q", dif.Cociente, 8'h00);
      check("rst r", dif.Residuo, 8'h00);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(8'd25, 8'd1, "25/1");
    run_op(8'hE6, 8'hFF, "-26/-1");
    run_op(8'hF9, 8'd2, "-7/2");
    run_op(8'd7, 8'hFE, "7/-2");
    run_op(8'd100, 8'd7, "100/7");
    run_op(8'd5, 8'd0, "5/0");
    run_op(8'h80, 8'hFF, "-128/-1");
    run_op(8'h80, 8'd1, "-128/1");
    run_op(8'h80, 8'd0, "-128/0");
    run_op(8'h7F, 8'h80, "127/-128");

    run_change(8'd100, 8'd9, 8'hC4, 8'd5);

    // Reset dropped partway through CALC must clear outputs without a clock edge.
    dif.A = 8'd90;
    dif.B = 8'd4;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async rst q", dif.Cociente, 8'h00);
    check("async rst r", dif.Residuo, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("held rst q", dif.Cociente, 8'h00);
    check("held rst r", dif.Residuo, 8'h00);
    exp_q = 8'h00;
    exp_r = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    run_op(8'd90, 8'd4, "post rst");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = pick_operand();
      rb = pick_operand();
      run_op(ra, rb, $sformatf("rnd %0d (%h/%h)", i, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/divisor.md
Name: divisor

Overview:
- Sequential signed 8-bit integer divider for the ALU datapath.
- Continuously samples dividend A and divisor B, runs a fixed-length restoring division and updates registered quotient (Cociente) and remainder (Residuo).
- No handshake ports. Results refresh every fixed-length computation period while out of reset.

Parameters:
- WIDTH, 8, operand/result width in bits; iteration count equals WIDTH.
- All ports below are WIDTH bits, shown at the default of 8.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- A  input  8  dividend, signed two's complement.
- B  input  8  divisor, signed two's complement.
- Cociente  output  8  quotient, signed, registered.
- Residuo  output  8  remainder, signed, registered.

Behaviour:
- Reset:
  - Interface: one clock (clk); reset rst is asynchronous and active-low.
  - While rst=0: Cociente=0, Residuo=0, FSM in LOAD, all internal registers 0.
  - Outputs stay 0 for as long as rst is held low.
  - Reset asserted mid-computation aborts it immediately.
  - The first LOAD occurs at the first rising clk edge after rst goes high.
- Arithmetic (signed):
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend (or is 0).
  - A = Cociente*B + Residuo, with |Residuo| < |B|.
- Special cases:
  - Divide by zero (B=0): Cociente=8'hFF, Residuo=A.
  - Overflow (A=-128, B=-1): Cociente=8'h80 (-128), Residuo=0. No wrap error flag.
- FSM, states LOAD -> CALC -> DONE -> LOAD, free-running:
  - LOAD, 1 cycle:
    - Sample A and B into internal registers.
    - Record sign_q = A[7]^B[7] and sign_r = A[7].
    - Form unsigned magnitudes |A| and |B| in 9 bits so |-128| = 128.
    - Clear the partial remainder and the iteration counter.
  - CALC, WIDTH=8 cycles, restoring division, MSB first, one quotient bit per cycle:
    - Shift {partial remainder, dividend magnitude} left by 1.
    - Trial-subtract |B|.
    - If the result is non-negative, keep it and set quotient bit = 1; otherwise restore and set quotient bit = 0.
    - Partial remainder is 9 bits wide.
  - DONE, 1 cycle:
    - Apply the signs: negate the quotient if sign_q, negate the remainder if sign_r.
    - Apply the divide-by-zero override when the sampled B = 0.
    - Register Cociente and Residuo.
    - Go to LOAD.
- Timing:
  - Period is 10 clocks.
  - Operands sampled at LOAD edge k appear on the outputs after edge k+9 (DONE edge).
  - Outputs change only on DONE edges; otherwise they hold the previous result.
- Input changes:
  - Changes to A/B during CALC or DONE are ignored until the next LOAD.
  - Inputs are sampled only at LOAD, so no setup beyond the normal synchronous requirement is needed.
- Results are never partial: Cociente and Residuo always update together on the same edge.

Test Plan:
- Hold rst=0 with A=25, B=1 and toggle clk -> Cociente=0, Residuo=0 throughout. Release rst, A=25, B=1 -> after 10 clocks Cociente=25 (8'h19), Residuo=0.
- A=-26 (8'hE6), B=-1 (8'hFF) -> Cociente=26 (8'h1A), Residuo=0. Also A=-7, B=2 -> Cociente=-3 (8'hFD), Residuo=-1 (8'hFF).
- A=7, B=-2 -> Cociente=8'hFD, Residuo=1. A=100, B=7 -> Cociente=14, Residuo=2.
- A=5, B=0 -> Cociente=8'hFF, Residuo=5. A=-128, B=-1 -> Cociente=8'h80, Residuo=0. A=-128, B=1 -> Cociente=8'h80, Residuo=0.
- Change A/B during CALC -> in-flight result uses the old operands; the new operands appear one full period later.
- Assert rst low mid-CALC -> outputs go to 0 asynchronously, without waiting for a clk edge. After release, a fresh 10-cycle computation with the current A/B.
